// File: rtl/mc_cu.sv
// mc_cu: multicycle control unit for the MIPS-subset CPU.
//
// Sequences each instruction through IF/ID/EXE/MEM/WB and decodes
// state, opcode and function code into the write enables and mux selects
// of the multicycle datapath, which shares one ALU and one memory port.
//
// Ports
//   clock, resetn        rising-edge clock, asynchronous active-low reset
//   op, func             opcode / function field from IR
//   z                    ALU zero flag (used only for branches in EXE)
//   mem_ready            memory completes its access this cycle
//   wpc, wir, wmem, wreg PC / IR / memory / register-file write enables
//   iord, regrt, m2reg, jal, shift, alusrca, alusrcb, sext, aluc, pcsource
//                        datapath mux selects and ALU operation
//   state                current sequencer state, for debug
//
// Memory handshake: an access is issued from IF (fetch) or MEM (load/store)
// and completes in the cycle mem_ready=1. Until then the sequencer holds its
// state; write enables other than wmem are suppressed while waiting, and
// wmem stays asserted for the whole store.
module mc_cu (
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  state_t state_q, state_d;

  // Instruction decode
  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr, i_gt;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  logic is_alu_r, is_alu_i, is_shift, sext_dec;
  logic [3:0] aluc_dec;

  assign r_type = (op == 6'b000000);
  assign i_add  = r_type & (func == 6'b100000);
  assign i_sub  = r_type & (func == 6'b100010);
  assign i_and  = r_type & (func == 6'b100100);
  assign i_or   = r_type & (func == 6'b100101);
  assign i_xor  = r_type & (func == 6'b100110);
  assign i_sll  = r_type & (func == 6'b000000);
  assign i_srl  = r_type & (func == 6'b000010);
  assign i_sra  = r_type & (func == 6'b000011);
  assign i_jr   = r_type & (func == 6'b001000);
  assign i_gt   = r_type & (func == 6'b100111);
  assign i_addi = (op == 6'b001000);
  assign i_andi = (op == 6'b001100);
  assign i_ori  = (op == 6'b001101);
  assign i_xori = (op == 6'b001110);
  assign i_lw   = (op == 6'b100011);
  assign i_sw   = (op == 6'b101011);
  assign i_beq  = (op == 6'b000100);
  assign i_bne  = (op == 6'b000101);
  assign i_lui  = (op == 6'b001111);
  assign i_j    = (op == 6'b000010);
  assign i_jal  = (op == 6'b000011);

  assign is_shift = i_sll | i_srl | i_sra;
  assign is_alu_r = i_add | i_sub | i_and | i_or | i_xor | is_shift | i_gt;
  assign is_alu_i = i_addi | i_andi | i_ori | i_xori | i_lui;
  assign sext_dec = i_addi | i_lw | i_sw | i_beq | i_bne;

  always_comb begin
    aluc_dec = 4'b0000;
    if (i_sub | i_beq | i_bne)   aluc_dec = 4'b0100;
    else if (i_and | i_andi)     aluc_dec = 4'b0001;
    else if (i_or | i_ori)       aluc_dec = 4'b0101;
    else if (i_xor | i_xori)     aluc_dec = 4'b0010;
    else if (i_lui)              aluc_dec = 4'b0110;
    else if (i_sll)              aluc_dec = 4'b0011;
    else if (i_srl)              aluc_dec = 4'b0111;
    else if (i_sra)              aluc_dec = 4'b1111;
    else if (i_gt)               aluc_dec = 4'b1011;
  end

  // Ungated enables; reset gating is applied at the outputs.
  logic wpc_c, wir_c, wmem_c, wreg_c;

  always_comb begin
    state_d  = S_IF;
    wpc_c    = 1'b0;
    wir_c    = 1'b0;
    wmem_c   = 1'b0;
    wreg_c   = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    shift    = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    sext     = 1'b0;
    aluc     = 4'b0000;
    pcsource = 2'b00;
    case (state_q)
      S_IF: begin
        // ALU computes PC+4 while the fetch is outstanding.
        alusrcb = 2'b01;
        if (mem_ready) begin
          wir_c   = 1'b1;
          wpc_c   = 1'b1;
          state_d = S_ID;
        end else begin
          state_d = S_IF;
        end
      end
      S_ID: begin
        // Branch target PC + (sext(imm)<<2) lands in ALUOut for EXE.
        alusrcb = 2'b11;
        sext    = sext_dec;
        if (i_j | i_jal) begin
          wpc_c    = 1'b1;
          pcsource = 2'b11;
          wreg_c   = i_jal;
          jal      = i_jal;
        end else if (i_jr) begin
          wpc_c    = 1'b1;
          pcsource = 2'b10;
        end else if (is_alu_r | is_alu_i | i_lw | i_sw | i_beq | i_bne) begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        sext    = sext_dec;
        if (is_alu_r) begin
          alusrcb = 2'b00;
          aluc    = aluc_dec;
          shift   = is_shift;
          state_d = S_WB;
        end else if (is_alu_i) begin
          alusrcb = 2'b10;
          aluc    = aluc_dec;
          state_d = S_WB;
        end else if (i_lw | i_sw) begin
          alusrcb = 2'b10;
          state_d = S_MEM;
        end else if (i_beq | i_bne) begin
          alusrcb  = 2'b00;
          aluc     = 4'b0100;
          pcsource = 2'b01;
          wpc_c    = (i_beq & z) | (i_bne & ~z);
        end
      end
      S_MEM: begin
        iord   = 1'b1;
        wmem_c = i_sw;
        if (!mem_ready)  state_d = S_MEM;
        else if (i_lw)   state_d = S_WB;
      end
      S_WB: begin
        wreg_c = 1'b1;
        regrt  = ~r_type;
        m2reg  = i_lw;
      end
      default: state_d = S_IF;
    endcase
  end

  assign wpc   = wpc_c  & resetn;
  assign wir   = wir_c  & resetn;
  assign wmem  = wmem_c & resetn;
  assign wreg  = wreg_c & resetn;
  assign state = state_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IF;
    else         state_q <= state_d;
  end

endmodule

// File: tb/tb_mc_cu.sv
// Bench for mc_cu: directed scenarios followed by random instruction
// streams, each cycle compared against a phase-level reference model.
module tb_mc_cu;

  logic       clock = 1'b0;
  logic       resetn;
  logic [5:0] op, func;
  logic       z, mem_ready;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca, sext;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  mc_cu dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z),
    .mem_ready(mem_ready), .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg),
    .iord(iord), .regrt(regrt), .m2reg(m2reg), .jal(jal), .shift(shift),
    .alusrca(alusrca), .alusrcb(alusrcb), .sext(sext), .aluc(aluc),
    .pcsource(pcsource), .state(state)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference model
  localparam int C_J = 0, C_JAL = 1, C_JR = 2, C_BR = 3, C_ALUR = 4,
                 C_ALUI = 5, C_LW = 6, C_SW = 7, C_NOP = 8;
  localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4;

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      case (f)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h27: return C_ALUR;
        6'h08: return C_JR;
        default: return C_NOP;
      endcase
    end
    case (o)
      6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0f: return C_ALUI;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      6'h04, 6'h05: return C_BR;
      6'h02: return C_J;
      6'h03: return C_JAL;
      default: return C_NOP;
    endcase
  endfunction

  function automatic logic [3:0] aluc_of(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      case (f)
        6'h22: return 4'h4;
        6'h24: return 4'h1;
        6'h25: return 4'h5;
        6'h26: return 4'h2;
        6'h00: return 4'h3;
        6'h02: return 4'h7;
        6'h03: return 4'hf;
        6'h27: return 4'hb;
        default: return 4'h0;
      endcase
    end
    case (o)
      6'h04, 6'h05: return 4'h4;
      6'h0c: return 4'h1;
      6'h0d: return 4'h5;
      6'h0e: return 4'h2;
      6'h0f: return 4'h6;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic sext_of(input logic [5:0] o);
    return (o == 6'h08) || (o == 6'h23) || (o == 6'h2b) || (o == 6'h04) || (o == 6'h05);
  endfunction

  // {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca,
  //  alusrcb, sext, aluc, pcsource}
  function automatic logic [21:0] expect_vec(input int ph, input logic [5:0] o,
                                             input logic [5:0] f, input logic zz,
                                             input logic mr);
    logic e_wpc, e_wir, e_wmem, e_wreg, e_iord, e_regrt, e_m2reg, e_jal, e_shift, e_asa, e_sext;
    logic [1:0] e_asb, e_pcs;
    logic [3:0] e_aluc;
    logic [2:0] e_state;
    int cls;
    cls = classify(o, f);
    {e_wpc, e_wir, e_wmem, e_wreg, e_iord, e_regrt, e_m2reg, e_jal, e_shift, e_asa, e_sext} = '0;
    e_asb = 2'b00; e_pcs = 2'b00; e_aluc = 4'h0;
    e_state = 3'(ph);
    case (ph)
      P_IF: begin
        e_wpc = mr; e_wir = mr; e_asb = 2'b01;
      end
      P_ID: begin
        e_asb = 2'b11; e_sext = sext_of(o);
        if (cls == C_J || cls == C_JAL) begin
          e_wpc = 1'b1; e_pcs = 2'b11;
          e_wreg = (cls == C_JAL); e_jal = (cls == C_JAL);
        end else if (cls == C_JR) begin
          e_wpc = 1'b1; e_pcs = 2'b10;
        end
      end
      P_EXE: begin
        e_asa = 1'b1; e_sext = sext_of(o);
        if (cls == C_ALUR) begin
          e_aluc = aluc_of(o, f);
          e_shift = (f == 6'h00) || (f == 6'h02) || (f == 6'h03);
        end else if (cls == C_ALUI) begin
          e_asb = 2'b10; e_aluc = aluc_of(o, f);
        end else if (cls == C_LW || cls == C_SW) begin
          e_asb = 2'b10;
        end else if (cls == C_BR) begin
          e_aluc = 4'h4; e_pcs = 2'b01;
          e_wpc = (o == 6'h04) ? zz : ~zz;
        end
      end
      P_MEM: begin
        e_iord = 1'b1; e_wmem = (cls == C_SW);
      end
      default: begin
        e_wreg = 1'b1; e_regrt = (cls != C_ALUR); e_m2reg = (cls == C_LW);
      end
    endcase
    return {e_state, e_wpc, e_wir, e_wmem, e_wreg, e_iord, e_regrt, e_m2reg, e_jal,
            e_shift, e_asa, e_asb, e_sext, e_aluc, e_pcs};
  endfunction

  function automatic logic [21:0] observed();
    return {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca,
            alusrcb, sext, aluc, pcsource};
  endfunction

  task automatic check(input string tag, input logic [21:0] exp);
    logic [21:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: drive inputs just after the edge, check mid-cycle, advance.
  task automatic cycle(input string tag, input int ph, input logic [5:0] o,
                       input logic [5:0] f, input logic zz, input logic mr);
    op = o; func = f; z = zz; mem_ready = mr;
    #2;
    check(tag, expect_vec(ph, o, f, zz, mr));
    @(posedge clock);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one instruction to completion; z only matters in EXE, mem_ready
  // only in IF and MEM, so elsewhere both are randomized.
  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                           input logic zz, input int if_st, input int mem_st);
    int cls;
    cls = classify(o, f);
    for (int i = 0; i < if_st; i++) cycle({tag, "/if_stall"}, P_IF, o, f, rbit(), 1'b0);
    cycle({tag, "/if"}, P_IF, o, f, rbit(), 1'b1);
    cycle({tag, "/id"}, P_ID, o, f, rbit(), rbit());
    if (cls == C_J || cls == C_JAL || cls == C_JR || cls == C_NOP) return;
    cycle({tag, "/exe"}, P_EXE, o, f, zz, rbit());
    if (cls == C_BR) return;
    if (cls == C_LW || cls == C_SW) begin
      for (int i = 0; i < mem_st; i++) cycle({tag, "/mem_stall"}, P_MEM, o, f, rbit(), 1'b0);
      cycle({tag, "/mem"}, P_MEM, o, f, rbit(), 1'b1);
      if (cls == C_SW) return;
    end
    cycle({tag, "/wb"}, P_WB, o, f, rbit(), rbit());
  endtask

  logic [5:0] tab_op[24];
  logic [5:0] tab_fn[24];

  initial begin
    logic [21:0] exp_v;

    tab_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
               6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h0f, 6'h02,
               6'h03, 6'h00, 6'h3f, 6'h11};
    tab_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08, 6'h27,
               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
               6'h00, 6'h3e, 6'h00, 6'h00};

    // Reset: IF values with all enables suppressed even though mem_ready=1.
    resetn = 1'b0; op = 6'h00; func = 6'h20; z = 1'b0; mem_ready = 1'b1;
    @(posedge clock); #2;
    check("reset", expect_vec(P_IF, 6'h00, 6'h20, 1'b0, 1'b0));
    @(posedge clock); #1;
    resetn = 1'b1;

    // Directed scenarios
    run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
    run_instr("lw_stall2", 6'h23, 6'h00, 1'b0, 0, 2);
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0);
    run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 0, 0);
    run_instr("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0);
    run_instr("bne_z0", 6'h05, 6'h00, 1'b0, 0, 0);
    run_instr("jal", 6'h03, 6'h00, 1'b0, 0, 0);
    run_instr("sw_stall3", 6'h2b, 6'h00, 1'b0, 0, 3);
    run_instr("j_ifstall", 6'h02, 6'h00, 1'b0, 2, 0);
    run_instr("jr", 6'h00, 6'h08, 1'b0, 0, 0);
    run_instr("lui", 6'h0f, 6'h00, 1'b0, 0, 0);
    run_instr("undef", 6'h3f, 6'h00, 1'b0, 0, 0);

    // Reset asserted during EXE of sra: state drops to IF immediately.
    cycle("sra/if", P_IF, 6'h00, 6'h03, 1'b0, 1'b1);
    cycle("sra/id", P_ID, 6'h00, 6'h03, 1'b0, 1'b1);
    op = 6'h00; func = 6'h03; z = 1'b1; mem_ready = 1'b1;
    #2;
    check("sra/exe", expect_vec(P_EXE, 6'h00, 6'h03, 1'b1, 1'b1));
    resetn = 1'b0;
    #1;
    exp_v = expect_vec(P_IF, 6'h00, 6'h03, 1'b0, 1'b0);
    check("sra/reset_async", exp_v);
    @(posedge clock); #1;
    check("sra/reset_hold", exp_v);
    resetn = 1'b1;
    run_instr("after_reset_add", 6'h00, 6'h20, 1'b0, 0, 0);

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      int k;
      logic [5:0] fr;
      k = $urandom_range(0, 23);
      fr = (tab_op[k] == 6'h00) ? tab_fn[k] : 6'($urandom_range(0, 63));
      run_instr("rand", tab_op[k], fr, rbit(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
